// File: rtl/rst_req_pkg.sv
// rtl/rst_req_pkg.sv - shared types and constants for the reset-request controller
package rst_req_pkg;

    // Controller FSM: ASSERT holds the downstream reset request high
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ASSERT = 1'b1
    } state_t;

    // Bit positions inside the 4-bit cause register
    localparam int CAUSE_BTN = 0;
    localparam int CAUSE_SW  = 1;
    localparam int CAUSE_WD  = 2;
    localparam int CAUSE_POR = 3;

    // Bit positions of the keyed software command in io_din[15:0]
    localparam int CMD_REQ = 0;
    localparam int CMD_CLR = 1;

    localparam logic [15:0] DEFAULT_SW_KEY = 16'hA5C3;

    localparam logic [3:0] CAUSE_POR_VAL = 4'b1000;

    // Reset counter increment that sticks at 255 instead of wrapping
    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == 8'hFF) ? 8'hFF : value + 8'd1;
    endfunction

endpackage

// File: rtl/rst_req_btn_debounce.sv
// rtl/rst_req_btn_debounce.sv - button synchroniser, polarity fix, debounce and press pulse
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_req
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    // Level the raw pin shows when nobody is pressing the button
    localparam logic PIN_IDLE = BTN_ACTIVE_LOW ? 1'b1 : 1'b0;

    logic [1:0]    r_sync;
    logic          r_stable;
    logic [CW-1:0] r_cnt;
    logic          r_req;
    logic          w_btn_s;

    // 1 = pressed, regardless of how the pin is wired
    assign w_btn_s = BTN_ACTIVE_LOW ? ~r_sync[1] : r_sync[1];
    assign btn_req = r_req;

    // Two-flop synchroniser for the asynchronous pin
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= {2{PIN_IDLE}};
        end else begin
            r_sync <= {r_sync[0], btn_in};
        end
    end

    // Stable level only follows btn_s after it has disagreed for DEBOUNCE_CYCLES
    // consecutive cycles; a new press (released->pressed) emits one request pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stable <= 1'b0;
            r_cnt    <= '0;
            r_req    <= 1'b0;
        end else begin
            r_req <= 1'b0;
            if (w_btn_s != r_stable) begin
                if (r_cnt == CNT_LAST) begin
                    r_stable <= w_btn_s;
                    r_cnt    <= '0;
                    r_req    <= w_btn_s;
                end else begin
                    r_cnt <= r_cnt + CNT_ONE;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/rst_req.sv
// rtl/rst_req.sv - merges button, watchdog and software reset sources into a fixed pulse
module rst_req
    import rst_req_pkg::*;
#(
    parameter int          DEBOUNCE_CYCLES = 100000,
    parameter int          PULSE_LEN       = 16,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1,
    parameter logic [15:0] SW_KEY          = DEFAULT_SW_KEY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_in,
    input  logic        wd_timeout,
    input  logic        io_en,
    input  logic        io_we,
    input  logic [31:0] io_din,
    output logic [31:0] io_dout,
    output logic        io_ack,
    output logic        rst_out
);

    localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(PULSE_LEN - 1);
    localparam logic [PW-1:0] PCNT_ONE  = PW'(1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [PW-1:0] r_pcnt;
    logic [PW-1:0] w_pcnt_nxt;
    logic [3:0]    r_cause;
    logic [7:0]    r_count;

    logic          w_btn_req;
    logic          w_sw_wr;
    logic          w_sw_req;
    logic          w_sw_clr;
    logic [3:0]    w_src;
    logic          w_accept;
    logic [7:0]    w_count_base;
    logic          w_unused_din;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
    ) u_btn (
        .clk     (clk),
        .rst     (rst),
        .btn_in  (btn_in),
        .btn_req (w_btn_req)
    );

    // Keyed software command decode; a wrong key makes the write a no-op
    assign w_sw_wr  = io_en & io_we & (io_din[31:16] == SW_KEY);
    assign w_sw_req = w_sw_wr & io_din[CMD_REQ];
    assign w_sw_clr = w_sw_wr & io_din[CMD_CLR];
    assign w_unused_din = ^io_din[15:2];

    // Gather all request sources of this cycle into cause-register layout
    always_comb begin
        w_src            = '0;
        w_src[CAUSE_BTN] = w_btn_req;
        w_src[CAUSE_SW]  = w_sw_req;
        w_src[CAUSE_WD]  = wd_timeout;
    end

    // Next-state logic: IDLE accepts any request, ASSERT runs PULSE_LEN cycles and drops requests
    always_comb begin
        w_state_nxt = r_state;
        w_pcnt_nxt  = r_pcnt;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_pcnt_nxt = '0;
                if (|w_src) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                if (r_pcnt == PCNT_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_pcnt_nxt  = '0;
                end else begin
                    w_pcnt_nxt = r_pcnt + PCNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_pcnt_nxt  = '0;
            end
        endcase
    end

    // State and pulse counter; power-on reset starts a full pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_ASSERT;
            r_pcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pcnt  <= w_pcnt_nxt;
        end
    end

    // A software clear in the same cycle as an accepted request is applied first
    assign w_count_base = w_sw_clr ? 8'h00 : r_count;

    // Cause/count register, only cleared by power-on reset or a keyed clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cause <= CAUSE_POR_VAL;
            r_count <= 8'h00;
        end else if (w_accept) begin
            r_cause <= w_src;
            r_count <= sat_inc(w_count_base);
        end else if (w_sw_clr) begin
            r_cause <= 4'h0;
            r_count <= 8'h00;
        end
    end

    assign rst_out = (r_state == ST_ASSERT);
    assign io_ack  = io_en;
    assign io_dout = (io_en && !io_we) ? {16'h0000, r_count, 4'h0, r_cause} : 32'h0000_0000;

endmodule

// File: tb/tb_rst_req.sv
// tb/tb_rst_req.sv - randomized scoreboard bench for the reset-request controller
module tb_rst_req;

    localparam int DEB = 8;
    localparam int PL  = 4;

    logic        clk = 1'b1;
    logic        rst = 1'b0;
    logic        btn_in = 1'b1;
    logic        wd_timeout = 1'b0;
    logic        io_en = 1'b0;
    logic        io_we = 1'b0;
    logic [31:0] io_din = 32'h0;
    logic [31:0] io_dout;
    logic        io_ack;
    logic        rst_out;

    rst_req #(
        .DEBOUNCE_CYCLES (DEB),
        .PULSE_LEN       (PL),
        .BTN_ACTIVE_LOW  (1'b1),
        .SW_KEY          (16'hA5C3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_in     (btn_in),
        .wd_timeout (wd_timeout),
        .io_en      (io_en),
        .io_we      (io_we),
        .io_din     (io_din),
        .io_dout    (io_dout),
        .io_ack     (io_ack),
        .rst_out    (rst_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int start;
        int width;
    } pulse_t;

    pulse_t      exp_pulses[$];
    logic [31:0] exp_reads[$];
    int checks = 0;
    int failures = 0;

    // Reference model of the cause/count register and the busy window
    int m_cause = 8;
    int m_count = 0;
    int m_free_at = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_read();
        return {16'h0, 8'(m_count), 4'h0, 4'(m_cause)};
    endfunction

    // A request driven now is sampled at the next edge; it is taken only if the
    // previous pulse (PL cycles) and the return to idle are complete
    task automatic model_req(input logic [3:0] src, input bit clr);
        int r;
        pulse_t p;
        r = cyc + 1;
        if (clr) begin
            m_cause = 0;
            m_count = 0;
        end
        if (src != 4'h0 && r >= m_free_at) begin
            m_cause = int'(src);
            m_count = (m_count < 255) ? m_count + 1 : 255;
            p.start = r;
            p.width = PL;
            exp_pulses.push_back(p);
            m_free_at = r + PL + 1;
        end
    endtask

    // One bus/watchdog cycle: model first, then drive for exactly one clock
    task automatic drive(input bit wd, input bit en, input bit we, input logic [31:0] din);
        bit key;
        bit sw;
        bit clr;
        key = (din[31:16] == 16'hA5C3);
        sw  = en && we && key && din[0];
        clr = en && we && key && din[1];
        if (en && !we) exp_reads.push_back(model_read());
        model_req({1'b0, wd, sw, 1'b0}, clr);
        wd_timeout = wd;
        io_en = en;
        io_we = we;
        io_din = din;
        tick(1);
        wd_timeout = 1'b0;
        io_en = 1'b0;
        io_we = 1'b0;
        io_din = 32'h0;
    endtask

    task automatic do_read();
        drive(1'b0, 1'b1, 1'b0, $urandom());
    endtask

    task automatic do_wd();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic do_write(input logic [31:0] d);
        drive(1'b0, 1'b1, 1'b1, d);
    endtask

    // Monitor: checks every read and idle bus value, and every completed rst_out pulse
    bit in_p = 1'b0;
    int p_w = 0;
    int p_s = 0;
    always @(negedge clk) begin : monitor
        pulse_t e;
        chk("io_ack", {31'b0, io_ack}, {31'b0, io_en});
        if (io_en && !io_we) begin
            if (exp_reads.size() == 0) chk("read_unexpected", 32'd1, 32'd0);
            else chk("io_dout", io_dout, exp_reads.pop_front());
        end else begin
            chk("io_dout_idle", io_dout, 32'h0);
        end
        if (rst_out) begin
            if (!in_p) begin
                in_p = 1'b1;
                p_w = 1;
                p_s = cyc;
            end else begin
                p_w++;
            end
        end else if (in_p) begin
            in_p = 1'b0;
            if (exp_pulses.size() == 0) begin
                chk("pulse_unexpected", 32'(p_s), 32'hFFFF_FFFF);
            end else begin
                e = exp_pulses.pop_front();
                chk("pulse_width", 32'(p_w), 32'(e.width));
                if (e.start >= 0) chk("pulse_start", 32'(p_s), 32'(e.start));
            end
        end
    end

    initial begin : timeout
        #1000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin : stim
        pulse_t p;
        int n;
        // Power-on: rst high for 3 edges, pulse continues PL cycles after release
        p.start = 0;
        p.width = 3 + PL;
        exp_pulses.push_back(p);
        #2 rst = 1'b1;
        tick(1);
        do_read();
        tick(1);
        rst = 1'b0;
        m_free_at = cyc + PL + 1;
        tick(PL + 2);
        do_read();

        // Watchdog
        do_wd();
        tick(PL + 2);
        do_read();

        // Bouncy button then a held press: exactly one request
        n = 2 * $urandom_range(2, 4);
        for (int i = 0; i < n; i++) begin
            btn_in = i[0];
            tick($urandom_range(1, 3));
        end
        m_cause = 1;
        m_count = m_count + 1;
        p.start = -1;
        p.width = PL;
        exp_pulses.push_back(p);
        btn_in = 1'b0;
        tick(20);
        btn_in = 1'b1;
        tick(DEB + 10);
        do_read();

        // Software key, wrong key, keyed clear
        do_write(32'hA5C3_0001);
        tick(PL + 2);
        do_read();
        do_write(32'h1234_0001);
        tick(PL + 2);
        do_read();
        do_write(32'h1234_0002);
        do_read();
        do_write(32'hA5C3_0002);
        do_read();

        // Watchdog and keyed request together, then a watchdog during ASSERT
        drive(1'b1, 1'b1, 1'b1, 32'hA5C3_0001);
        do_wd();
        tick(PL + 2);
        do_read();

        // Clear+request in one write, then clear racing a watchdog
        do_write(32'hA5C3_0003);
        tick(PL + 2);
        do_read();
        drive(1'b1, 1'b1, 1'b1, 32'hA5C3_0002);
        tick(PL + 2);
        do_read();

        // Saturation with spaced requests, then random-gap requests
        for (int i = 0; i < 260; i++) begin
            do_wd();
            tick(PL + $urandom_range(0, 2));
        end
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) do_read();
            do_wd();
            tick($urandom_range(0, PL + 2));
        end
        tick(PL + 2);
        do_read();

        // Power-on reset during ASSERT restarts a full pulse with POR cause
        do_wd();
        tick(1);
        p = exp_pulses.pop_back();
        p.width = 1 + 2 + PL;
        exp_pulses.push_back(p);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        m_cause = 8;
        m_count = 0;
        m_free_at = cyc + PL + 1;
        tick(PL + 2);
        do_read();
        do_wd();
        tick(PL + 2);
        do_read();

        tick(5);
        chk("pulses_left", 32'(exp_pulses.size()), 32'd0);
        chk("reads_left", 32'(exp_reads.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
